// File: rtl/price_threshold_scheduler.sv
// Round-robin scheduler sharing one band-compare/debounce datapath among
// NUM_CH price feeds. Per-channel state, pending direction and debounce count
// live in register banks; the granted channel's context is read, updated and
// written back in a single cycle, so results appear one cycle after acceptance.
module price_threshold_scheduler #(
    parameter int NUM_CH          = 4,
    parameter int PRICE_W         = 8,
    parameter int UPPER_BAND      = 105,
    parameter int LOWER_BAND      = 95,
    parameter int DEBOUNCE_CYCLES = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_CH-1:0]           req_valid,
    input  logic [NUM_CH*PRICE_W-1:0]   req_price,
    output logic [NUM_CH-1:0]           req_ready,
    input  logic                        cfg_valid,
    input  logic [PRICE_W-1:0]          cfg_upper,
    input  logic [PRICE_W-1:0]          cfg_lower,
    output logic                        cfg_err,
    output logic                        out_valid,
    output logic [$clog2(NUM_CH)-1:0]   out_ch,
    output logic [1:0]                  out_state,
    output logic [2*NUM_CH-1:0]         state_vec
);
    localparam int CW = $clog2(NUM_CH);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

    // State and direction share one encoding so a classification can be
    // compared directly against the current state or pending direction.
    localparam logic [1:0] S_BAND = 2'b01;
    localparam logic [1:0] S_HIGH = 2'b11;
    localparam logic [1:0] S_LOW  = 2'b10;
    localparam logic [1:0] D_NONE = 2'b00;

    typedef struct packed {
        logic [1:0]    st;
        logic [1:0]    dir;
        logic [DW-1:0] cnt;
    } ch_ctx_t;

    logic [NUM_CH-1:0][1:0]    st_q;
    logic [NUM_CH-1:0][1:0]    dir_q;
    logic [NUM_CH-1:0][DW-1:0] cnt_q;
    logic [CW-1:0]             ptr_q;
    logic [PRICE_W-1:0]        upper_q, lower_q;

    logic [CW-1:0]      gnt_idx;
    logic               gnt_any;
    logic               accept;
    logic               cfg_ok;
    logic [PRICE_W-1:0] price;
    logic [1:0]         cls;
    logic [DW:0]        inc;
    ch_ctx_t            cur, nxt;

    assign state_vec = st_q;
    assign accept    = gnt_any & ~cfg_valid;
    assign cfg_ok    = cfg_lower < cfg_upper;

    // Round-robin search from ptr_q; scanning downward lets the closest
    // valid channel (smallest offset) win without an early exit.
    always_comb begin
        int j;
        j         = 0;
        gnt_idx   = '0;
        gnt_any   = 1'b0;
        req_ready = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            j = int'(ptr_q) + k;
            if (j >= NUM_CH) j = j - NUM_CH;
            if (req_valid[j]) begin
                gnt_idx = CW'(j);
                gnt_any = 1'b1;
            end
        end
        if (accept) req_ready[gnt_idx] = 1'b1;
    end

    // Shared datapath: classify the granted sample and advance its debounce.
    always_comb begin
        price = req_price[gnt_idx*PRICE_W +: PRICE_W];
        if (price >= upper_q)      cls = S_HIGH;
        else if (price <= lower_q) cls = S_LOW;
        else                       cls = S_BAND;
        cur = '{st: st_q[gnt_idx], dir: dir_q[gnt_idx], cnt: cnt_q[gnt_idx]};
        nxt = cur;
        inc = {1'b0, cur.cnt} + 1'b1;
        if (cls == S_BAND) begin
            nxt.st  = S_BAND;
            nxt.dir = D_NONE;
            nxt.cnt = '0;
        end else if (cls == cur.st) begin
            // Already in the matching extreme: nothing pending.
            nxt.dir = D_NONE;
            nxt.cnt = '0;
        end else begin
            if (cur.dir != cls || cur.cnt == '0) inc = (DW+1)'(1);
            if (inc >= (DW+1)'(DEBOUNCE_CYCLES)) begin
                nxt.st  = cls;
                nxt.dir = D_NONE;
                nxt.cnt = '0;
            end else begin
                nxt.dir = cls;
                nxt.cnt = inc[DW-1:0];
            end
        end
    end

    // Register banks, bands, RR pointer and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) st_q[i] <= S_BAND;
            dir_q     <= '0;
            cnt_q     <= '0;
            ptr_q     <= '0;
            upper_q   <= PRICE_W'(UPPER_BAND);
            lower_q   <= PRICE_W'(LOWER_BAND);
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_state <= S_BAND;
            cfg_err   <= 1'b0;
        end else begin
            out_valid <= accept;
            cfg_err   <= cfg_valid & ~cfg_ok;
            if (accept) begin
                out_ch          <= gnt_idx;
                out_state       <= nxt.st;
                st_q[gnt_idx]   <= nxt.st;
                dir_q[gnt_idx]  <= nxt.dir;
                cnt_q[gnt_idx]  <= nxt.cnt;
                ptr_q           <= (gnt_idx == CW'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
            end
            if (cfg_valid && cfg_ok) begin
                upper_q <= cfg_upper;
                lower_q <= cfg_lower;
                dir_q   <= '0;
                cnt_q   <= '0;
            end
        end
    end
endmodule

// File: doc/price_threshold_scheduler.md
Name: price_threshold_scheduler

Overview:
Shares one threshold-evaluation datapath (band compare plus debounce) among NUM_CH independent price feeds, using round-robin arbitration with a valid/ready handshake. Per-channel HIGH/BAND/LOW state and debounce progress are stored in register banks. The block also owns run-time configuration of the upper and lower bands. It sits between the market-data feed demux and downstream signal logic.

Parameters:
NUM_CH, 4, number of price feeds (>=2)
PRICE_W, 8, price sample width (unsigned)
UPPER_BAND, 105, reset value of upper band
LOWER_BAND, 95, reset value of lower band (must be < UPPER_BAND)
DEBOUNCE_CYCLES, 3, consecutive accepted extreme samples required to enter HIGH/LOW (>=1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  NUM_CH  per-channel sample valid
req_price  in  NUM_CH*PRICE_W  per-channel price; channel i is bits [i*PRICE_W +: PRICE_W]
req_ready  out  NUM_CH  one-hot grant (combinational); a sample is accepted when valid&ready
cfg_valid  in  1  band-write request
cfg_upper  in  PRICE_W  new upper band
cfg_lower  in  PRICE_W  new lower band
cfg_err  out  1  one-cycle pulse: config write rejected
out_valid  out  1  one-cycle pulse: result for one accepted sample
out_ch  out  $clog2(NUM_CH)  channel of result
out_state  out  2  updated state: 01 BAND, 11 HIGH, 10 LOW
state_vec  out  2*NUM_CH  live state of all channels, registered

Behaviour:
- Reset (async assert, sync release): all channel states 01, debounce counters 0, pending direction NONE, RR pointer 0, bands = UPPER_BAND/LOWER_BAND, out_valid 0, out_ch 0, out_state 01, cfg_err 0. Asserting reset mid-operation discards in-flight results; no out_valid is produced for them.
- Arbitration: grant the first channel with req_valid set, searching from the RR pointer upward and wrapping at NUM_CH. At most one req_ready bit is high. On acceptance, the pointer moves to granted+1 (mod NUM_CH); otherwise it holds. req_ready is all-zero when no channel is valid or when cfg_valid=1.
- Latency: the result appears on out_valid/out_ch/out_state in the cycle after acceptance. state_vec updates on the same edge. Back-to-back acceptances give one result per cycle.
- Classification: EXT_HI if price >= upper; EXT_LO if price <= lower; otherwise IN. Comparisons are unsigned.
- Debounce is counted in accepted samples of that channel, not clock cycles. Counter width is $clog2(DEBOUNCE_CYCLES+1) and it saturates at DEBOUNCE_CYCLES.
- State BAND:
  - IN clears the counter.
  - EXT_HI or EXT_LO increments the counter if its direction matches the pending direction; otherwise the counter restarts at 1 with the new direction.
  - When the counter reaches DEBOUNCE_CYCLES, enter HIGH or LOW and clear the counter.
- State HIGH:
  - IN goes to BAND immediately.
  - EXT_HI stays HIGH and clears the counter.
  - EXT_LO debounces as above; at DEBOUNCE_CYCLES it goes directly to LOW.
- State LOW: mirror of HIGH (IN goes to BAND; EXT_HI debounces to HIGH).
- DEBOUNCE_CYCLES=1: the first extreme sample transitions immediately.
- Config: cfg_valid has priority and stalls all sample acceptance that cycle.
  - If cfg_lower < cfg_upper, the new bands apply to samples accepted from the next cycle, all debounce counters and pending directions clear, and channel states are kept.
  - Otherwise the bands are unchanged and cfg_err pulses the next cycle.
- A channel with no grant keeps its state and counter indefinitely; gaps between its samples do not break its debounce sequence.

Test Plan:
- Single channel 0, prices 100,110,106,107,115,104 -> out_state 01,01,01,11,11,01; each out_valid is one cycle after acceptance.
- Ch1 prices 90,93,92,94,101 -> 01,01,10,10,01. Ch1 interrupted run 110,100,95,101 -> all 01 with the counter restarted each time.
- From HIGH: 95,93,92 -> 11,11,10. From LOW: 107 then 96 -> 10 then 01.
- All 4 channels valid continuously -> grants 0,1,2,3,0,... one per cycle. Ch2 alone valid with pointer at 3 -> grant 2 after wrap; no starvation across 16 cycles.
- Mid-debounce (ch0 at count 2, price 110) apply cfg 120/80 -> no grant that cycle, counter cleared; next 110 on ch0 -> 01 stays BAND. cfg 90/90 -> cfg_err pulse and bands unchanged.
- Assert reset with ch3 in HIGH and a sample in flight -> out_valid 0, state_vec all 01, pointer 0 after release.
